// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of a single-port data memory.
// Define DMEM_ARB_RANGE_CHECK_EN to reject addresses >= DEPTH with an err pulse.
module dmem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          done0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          done1,
    output logic          err1,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state_q;
    logic          last_gnt_q;
    logic          owner_q;
    logic          we_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          done0_q;
    logic          done1_q;
    logic          err0_q;
    logic          err1_q;

    logic          elig0_d;
    logic          elig1_d;
    logic          gnt_vld_d;
    logic          gnt_d;
    logic          sel_we_d;
    logic [AW-1:0] sel_addr_d;
    logic [DW-1:0] sel_wdata_d;
    logic          oor_d;

    // A port whose done/err pulse is high this cycle is not re-served.
    always_comb begin
        elig0_d     = req0 & ~done0_q & ~err0_q;
        elig1_d     = req1 & ~done1_q & ~err1_q;
        gnt_vld_d   = elig0_d | elig1_d;
        gnt_d       = (elig0_d & elig1_d) ? ~last_gnt_q : elig1_d;
        sel_we_d    = gnt_d ? we1 : we0;
        sel_addr_d  = gnt_d ? addr1 : addr0;
        sel_wdata_d = gnt_d ? wdata1 : wdata0;
    end

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign oor_d = (sel_addr_d >= AW'(DEPTH));
`else
    logic unused_depth;
    assign unused_depth = (DEPTH > 0);
    assign oor_d        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        if (oor_d) begin
                            if (gnt_d) err1_q <= 1'b1;
                            else       err0_q <= 1'b1;
                            last_gnt_q <= gnt_d;
                        end else begin
                            owner_q     <= gnt_d;
                            we_q        <= sel_we_d;
                            mem_addr_q  <= sel_addr_d;
                            mem_wdata_q <= sel_wdata_d;
                            mem_write_q <= sel_we_d;
                            mem_read_q  <= ~sel_we_d;
                            state_q     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner_q) rdata1_q <= mem_rdata;
                        else         rdata0_q <= mem_rdata;
                    end
                    if (owner_q) done1_q <= 1'b1;
                    else         done0_q <= 1'b1;
                    last_gnt_q  <= owner_q;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64x32 async-read/sync-write memory model.
// Range-check sequence is compiled in only with DMEM_ARB_RANGE_CHECK_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic        done0, done1, err0, err1, mem_read, mem_write;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .done0(done0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .done1(done1), .err1(err1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

    int          wr_cnt = 0, multi_cnt = 0, err_cnt = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    always @(posedge clk) begin
        if (!reset && mem_write) begin
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if ($countones({done0, done1, err0, err1}) > 1) multi_cnt++;
        if (mem_read && mem_write) multi_cnt++;
        if (err0 || err1) err_cnt++;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit r, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    // Single transaction on one port, called at a negedge.
    task automatic run_txn(input string tag, input bit p, input bit we,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp);
        int w0;
        int lat;
        bit seen;
        logic [31:0] rd;
        w0 = wr_cnt;
        lat = 0;
        seen = 1'b0;
        drive(p, 1'b1, we, a, d);
        @(negedge clk);
        check({tag, " strobes"}, {30'd0, mem_write, mem_read},
              we ? 32'd2 : 32'd1);
        check({tag, " mem_addr"}, mem_addr, a);
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (p ? done1 : done0) seen = 1'b1;
            else lat++;
        end
        check({tag, " done seen"}, {31'd0, seen}, 32'd1);
        check({tag, " latency"}, lat, 0);
        drive(p, 1'b0, 1'b0, a, d);
        rd = p ? rdata1 : rdata0;
        if (we) begin
            check({tag, " write count"}, wr_cnt - w0, 1);
            check({tag, " write addr"}, last_waddr, a);
            check({tag, " write data"}, last_wdata, d);
        end else begin
            check({tag, " rdata"}, rd, exp);
            check({tag, " write count"}, wr_cnt - w0, 0);
        end
        @(negedge clk);
        check({tag, " done pulse"}, {31'd0, p ? done1 : done0}, 32'd0);
        check({tag, " rdata held"}, p ? rdata1 : rdata0, rd);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int t0, t1, nd, w0;
        logic [31:0] r0, r1;
        int seq [$];
        int tim [$];
        bit seen;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[3] = 32'd33;
        mem[5] = 32'd55;

        tbl[0] = '{1'b0, 1'b1, 32'd17, 32'd56, 32'd0};
        tbl[1] = '{1'b0, 1'b0, 32'd17, 32'd0, 32'd56};
        tbl[2] = '{1'b1, 1'b1, 32'd5, 32'hA5A5, 32'd0};
        tbl[3] = '{1'b0, 1'b0, 32'd5, 32'd0, 32'hA5A5};
        tbl[4] = '{1'b1, 1'b0, 32'd17, 32'd0, 32'd56};
        tbl[5] = '{1'b1, 1'b1, 32'd63, 32'hDEADBEEF, 32'd0};
        tbl[6] = '{1'b0, 1'b0, 32'd63, 32'd0, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 1'b1, 32'd0, 32'h1234, 32'd0};
        tbl[8] = '{1'b1, 1'b0, 32'd0, 32'd0, 32'h1234};

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle c%0d ctl", c),
                  {26'd0, mem_read, mem_write, done0, done1, err0, err1}, 32'd0);
            check($sformatf("idle c%0d data", c), rdata0 | rdata1 | mem_addr | mem_wdata, 32'd0);
        end

        // Simultaneous requests straight after reset: port 0 wins the tie.
        drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
        t0 = -1; t1 = -1; r0 = '0; r1 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done0 && t0 < 0) begin t0 = c; r0 = rdata0; req0 = 1'b0; end
            if (done1 && t1 < 0) begin t1 = c; r1 = rdata1; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie done0 cycle", t0, 2);
        check("tie done1 gap", t1 - t0, 2);
        check("tie rdata0", r0, 32'd33);
        check("tie rdata1", r1, 32'd55);

        for (int i = 0; i < 9; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].we,
                    tbl[i].addr, tbl[i].wdata, tbl[i].exp);

        // Both ports held high: grants must alternate every two cycles.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
        for (int c = 0; c < 40 && seq.size() < 8; c++) begin
            @(negedge clk);
            if (done0) begin seq.push_back(0); tim.push_back(c); end
            if (done1) begin seq.push_back(1); tim.push_back(c); end
        end
        req0 = 1'b0; req1 = 1'b0;
        nd = seq.size();
        check("alt count", nd, 8);
        if (nd > 0) check("alt first", seq[0], 0);
        for (int i = 1; i < nd; i++) begin
            check($sformatf("alt port %0d", i), seq[i], 1 - seq[i-1]);
            check($sformatf("alt gap %0d", i), tim[i] - tim[i-1], 2);
        end
        repeat (3) @(negedge clk);

        // Reset during the access cycle of a store must not commit it.
        w0 = wr_cnt;
        drive(1'b0, 1'b1, 1'b1, 32'd15, 32'd65);
        @(negedge clk);
        check("rst store strobe", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst strobe drop", {30'd0, mem_write, mem_read}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done0 || done1) seen = 1'b1;
        end
        check("rst no done", {31'd0, seen}, 32'd0);
        check("rst no write", wr_cnt - w0, 0);
        run_txn("rst reload", 1'b0, 1'b0, 32'd15, 32'd0, 32'd0);

`ifdef DMEM_ARB_RANGE_CHECK_EN
        w0 = wr_cnt;
        seen = 1'b0;
        t0 = -1;
        drive(1'b1, 1'b1, 1'b1, 32'd64, 32'd9);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (err1 && t0 < 0) begin t0 = c; req1 = 1'b0; end
            if (done1) seen = 1'b1;
        end
        req1 = 1'b0;
        check("range err1 cycle", t0, 1);
        check("range no done", {31'd0, seen}, 32'd0);
        check("range no write", wr_cnt - w0, 0);
        check("range err count", err_cnt, 1);
        run_txn("range reload", 1'b0, 1'b0, 32'd0, 32'd0, 32'h1234);
`else
        check("err tied low", err_cnt, 0);
`endif

        check("exclusive pulses", multi_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
